// File: rtl/jtag_drv_pkg.sv
// Shared types and sequence lengths for the host-side JTAG TAP driver.
package jtag_drv_pkg;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_IDLE    = 2'd1,
    OP_SCAN_IR = 2'd2,
    OP_SCAN_DR = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_BOOT_RST,
    S_READY,
    S_PRE,
    S_SHIFT,
    S_POST,
    S_IDLE_RUN,
    S_DONE
  } state_e;

  localparam int DR_PRE  = 3;
  localparam int IR_PRE  = 4;
  localparam int POST    = 2;
  localparam int RST_LEN = 6;

endpackage

// File: rtl/jtag_tap_driver.sv
// JTAG master: turns RESET/IDLE/SCAN_IR/SCAN_DR commands into registered TMS/TDI
// streams on tck and gathers TDO into the response vector.
module jtag_tap_driver
  import jtag_drv_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [MAX_LEN-1:0]   sr_q, sr_d;
  logic [MAX_LEN-1:0]   cap_q, cap_d;
  logic                 cap_en_q, cap_en_d;
  logic [IDX_W-1:0]     cap_idx_q, cap_idx_d;
  logic                 tms_q, tms_d;
  logic                 tdi_q, tdi_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0]   rsp_data_q, rsp_data_d;
  logic [LEN_W-1:0]     cnt_inc;
  logic [LEN_W-1:0]     pre_last;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) return LEN_W'(1);
    if (l > LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sr_d        = sr_q;
    cap_d       = cap_q;
    cap_en_d    = 1'b0;
    cap_idx_d   = cap_idx_q;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    cnt_inc     = cnt_q + LEN_W'(1);
    pre_last    = (op_q == OP_SCAN_IR) ? LEN_W'(IR_PRE - 1) : LEN_W'(DR_PRE - 1);

    // The TAP consumes a shift bit one edge after it is driven; TDO is valid then.
    if (cap_en_q) cap_d[cap_idx_q] = tdo;

    case (state_q)
      S_BOOT_RST: begin
        cnt_d = cnt_inc;
        if (cnt_q == LEN_W'(RST_LEN - 1)) begin
          tms_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          tms_d = 1'b1;
        end
      end
      S_READY: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          op_d        = op_e'(cmd_op);
          len_d       = clamp_len(cmd_len);
          sr_d        = cmd_data;
          cap_d       = '0;
          cnt_d       = '0;
          case (op_e'(cmd_op))
            OP_RESET: state_d = S_BOOT_RST;
            OP_IDLE:  state_d = S_IDLE_RUN;
            default:  state_d = S_PRE;
          endcase
        end
      end
      S_PRE: begin
        cnt_d = cnt_inc;
        tms_d = (cnt_q == '0) || ((op_q == OP_SCAN_IR) && (cnt_q == LEN_W'(1)));
        if (cnt_q == pre_last) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        tdi_d     = sr_q[0];
        sr_d      = sr_q >> 1;
        cap_en_d  = 1'b1;
        cap_idx_d = cnt_q[IDX_W-1:0];
        cnt_d     = cnt_inc;
        if (cnt_q == len_q - LEN_W'(1)) begin
          tms_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_POST;
        end
      end
      S_POST: begin
        tms_d = (cnt_q == '0);
        cnt_d = cnt_inc;
        if (cnt_q == LEN_W'(POST - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_IDLE_RUN: begin
        cnt_d = cnt_inc;
        if (cnt_q == len_q - LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid_d = 1'b1;
        cmd_ready_d = 1'b1;
        rsp_data_d  = cap_q;
        state_d     = S_READY;
      end
      default: state_d = S_BOOT_RST;
    endcase
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      state_q     <= S_BOOT_RST;
      cnt_q       <= '0;
      cap_q       <= '0;
      cap_en_q    <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      cap_en_q    <= cap_en_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Command payload is only consumed in states reachable after acceptance.
  always_ff @(posedge tck) begin
    op_q      <= op_d;
    len_q     <= len_d;
    sr_q      <= sr_d;
    cap_idx_q <= cap_idx_d;
  end

endmodule

// File: doc/jtag_tap_driver.md
Name: jtag_tap_driver

Overview:
Host-side JTAG master that sequences the TAP of our test logic. It accepts one command at a time (TAP reset, idle cycles, IR scan, DR scan) and generates the TMS/TDI bit stream, clocked on the same tck that drives the TAP. For scans it collects TDO and returns the captured vector. Used in on-chip self-test and as the bench driver for the TAP/BSR logic.

Parameters:
MAX_LEN, 32, maximum scan/idle length in bits
LEN_W, $clog2(MAX_LEN+1), width of the cmd_len field

Ports:
tck  input  1  single clock
trst  input  1  reset, synchronous, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  driver can accept a command
cmd_op  input  2  0=RESET, 1=IDLE, 2=SCAN_IR, 3=SCAN_DR
cmd_len  input  LEN_W  bit count for IDLE/SCAN
cmd_data  input  MAX_LEN  TDI vector, bit 0 shifted first
rsp_valid  output  1  one-cycle pulse: command complete
rsp_data  output  MAX_LEN  captured TDO, bit 0 = first bit out
tms  output  1  to TAP
tdi  output  1  to TAP
tdo  input  1  from TAP

Behaviour:
- Clock is tck; reset is synchronous and active-high (trst); all state updates on tck rising edge.
- Reset values: tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0.
- After reset release, the driver automatically runs the RESET sequence. cmd_ready rises only when that sequence completes.
- tms/tdi are registered. A value driven at edge k is sampled by the TAP at edge k+1.
- Between commands the TAP is held in Run-Test/Idle with tms=0 and tdi=0.
- Handshake: a command is accepted on an edge where cmd_valid and cmd_ready are both 1. cmd_ready drops on the next edge and stays low until the command's last bit has been driven. cmd_op, cmd_len and cmd_data are latched at acceptance.
- Bit sequences, starting with the bit driven on the edge after acceptance:
  - RESET: tms = 1,1,1,1,1,0 (6 bits).
  - IDLE: tms = 0 repeated N times.
  - SCAN_DR: tms = 1,0,0, then N shift bits (0 … 0, last bit 1), then 1,0. Total N+5 bits.
  - SCAN_IR: tms = 1,1,0,0, then N shift bits, then 1,0. Total N+6 bits.
- Shift bit i: tdi = cmd_data[i]. tdi = 0 outside shift bits.
- TDO capture: tdo is sampled on the edge at which the TAP consumes shift bit i, and stored in rsp_data[i]. rsp_data[MAX_LEN-1:N] = 0.
- Length rules: N = cmd_len. cmd_len = 0 is treated as 1. cmd_len > MAX_LEN is clamped to MAX_LEN.
- Completion:
  - rsp_valid pulses for exactly one cycle, on the edge after the last bit is driven, for every op.
  - rsp_data is zero for RESET and IDLE.
  - rsp_data holds its value until the next rsp_valid.
  - cmd_ready rises in the same cycle as rsp_valid. There is no response backpressure.
- FSM states: BOOT_RST, READY, PRE (state-entry tms prefix), SHIFT, POST (exit/update suffix), IDLE_RUN, DONE. A bit counter and a shift register are shared by all states.
- trst asserted mid-command: abort on that edge, apply reset values, no rsp_valid for the aborted command, then rerun BOOT_RST.
- cmd_valid while cmd_ready=0: ignored, not queued.

Decomposition:
- Package jtag_drv_pkg holds: the op enum (RESET/IDLE/SCAN_IR/SCAN_DR), the FSM state enum, and the prefix/suffix lengths as constants (DR_PRE=3, IR_PRE=4, POST=2, RST_LEN=6).
- No sub-module: the block is a single FSM with a LEN_W counter and a MAX_LEN shift register.

Test Plan:
- Reset release, trst high for 2 edges → tms sequence 1,1,1,1,1,0; cmd_ready=1 at the 7th edge after release; rsp_valid=1 for one cycle.
- SCAN_IR, len=4, data=4'b0001 → tms = 1,1,0,0,0,0,0,1,1,0; tdi=1 on the first shift bit only; rsp_data=4'b0001 (IR capture pattern); TAP IR holds IDCODE.
- After IR=IDCODE: SCAN_DR, len=32, data=0 → rsp_data equals the device IDCODE with bit 0 = 1; 37 bits driven.
- BYPASS selected: SCAN_DR, len=8, data=8'hA5 → rsp_data=8'h4A (bypass 0 followed by data[6:0]).
- Edge cases:
  - IDLE, len=0 → exactly 1 tms=0 bit, then rsp_valid.
  - SCAN_DR, len=40 with MAX_LEN=32 → 37 bits driven.
- trst asserted during the 10th shift bit of a 32-bit DR scan → next edge tms=1, cmd_ready=0, no rsp_valid, full RESET sequence replayed.
